// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Drives the single write port of the general-purpose register file. Each cycle
// it chooses between the single-cycle ALU result stream and the head of a small
// in-order queue that holds results from long-latency units (mul/div/load).
// The ALU always wins. Writes to register 0 are dropped. A queued result whose
// destination is overwritten by a younger ALU write is squashed, so its later
// pop writes nothing. When queued results wait too long, a one-cycle stall
// request makes the pipeline leave a free slot for the queue.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   alu_valid/alu_waddr/alu_wdata ALU result (no backpressure)
//   ll_valid/ll_waddr/ll_wdata    long-latency result offer
//   ll_ready                      queue accepts; transfer on ll_valid && ll_ready
//   we/waddr/wdata                registered register-file write port
//   stall_req                     pipeline must present alu_valid=0 next cycle
//   ll_pending                    queue holds at least one live entry
//   proto_err                     sticky: alu_valid seen while stall_req high
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [ADDR_W-1:0] ll_waddr,
  input  logic [DATA_W-1:0] ll_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall_req,
  output logic              ll_pending,
  output logic              proto_err
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);
  localparam logic [SCNT_W-1:0] STARVE_PRE = SCNT_W'(STARVE_LIMIT - 1);

  // Queue storage
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  // Arbitration state and registered write port
  logic [SCNT_W-1:0] r_starve;
  logic              r_stall;
  logic              r_proto_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_alu_win;
  logic              w_push;
  logic              w_pop;
  logic              w_push_live;
  logic              w_unserved;
  logic              w_head_live;
  logic [DEPTH-1:0]  w_live_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  // Ready depends on the registered count only: a full queue does not accept
  // a push even in a cycle where it pops.
  assign ll_ready    = (r_count < FULL_CNT);

  assign w_alu_win   = alu_valid && (alu_waddr != '0);
  assign w_push      = ll_valid && ll_ready;
  assign w_pop       = !w_alu_win && (r_count != '0);
  assign w_unserved  = (r_count != '0) && !w_pop;
  assign w_head_live = r_live[r_rd_ptr];

  // A push to r0 is stored dead; so is a push the same-cycle ALU write overrides.
  assign w_push_live = (ll_waddr != '0) && !(w_alu_win && (ll_waddr == alu_waddr));

  // Live-bit update. Squash and pop target different slots from the push
  // (push goes to the tail, which never equals the popped head unless the
  // queue is empty or full, and neither case allows both), so ordering the
  // updates this way is safe.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_live_nxt = r_live;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_win && (r_addr[i] == alu_waddr)) w_live_nxt[i] = 1'b0;
      if (w_pop && (r_rd_ptr == PTR_W'(i)))      w_live_nxt[i] = 1'b0;
      if (w_push && (r_wr_ptr == PTR_W'(i)))     w_live_nxt[i] = w_push_live;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue control and arbitration state
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) begin
      r_live      <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
      r_proto_err <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_live  <= w_live_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      // Starvation: counts cycles where live-or-dead entries wait without a
      // pop. The pulse fires on the last tolerated cycle so the next cycle,
      // with the pipeline holding off the ALU, is a guaranteed pop.
      if ((r_count == '0) || w_pop) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_MAX) begin
        r_starve <= r_starve + SCNT_W'(1);
      end
      r_stall <= (r_starve == STARVE_PRE) && w_unserved;

      if (alu_valid && r_stall) r_proto_err <= 1'b1;

      r_we <= w_alu_win || (w_pop && w_head_live);
      if (w_alu_win) begin
        r_waddr <= alu_waddr;
        r_wdata <= alu_wdata;
      end else if (w_pop && w_head_live) begin
        r_waddr <= r_addr[r_rd_ptr];
        r_wdata <= r_data[r_rd_ptr];
      end
    end
  end

  // Payload storage
  // NOTE: address/data slots are not reset; validity is carried entirely by
  // r_live and r_count, so stale payload is never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= ll_waddr;
      r_data[r_wr_ptr] <= ll_wdata;
    end
  end

  // Popped and squashed slots always have their live bit cleared, so a live
  // bit implies a valid entry.
  assign ll_pending = |r_live;
  assign stall_req  = r_stall;
  assign proto_err  = r_proto_err;
  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Table of per-cycle input vectors with hand-derived expected outputs. Each
// vector's expectation is queued when it is driven and compared one cycle
// later against the registered outputs. Reset state and a reset with queued
// entries are checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NVEC   = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              ll_valid;
  logic              ll_ready;
  logic [ADDR_W-1:0] ll_waddr;
  logic [DATA_W-1:0] ll_wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              stall_req;
  logic              ll_pending;
  logic              proto_err;

  regfile_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(2), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req), .ll_pending(ll_pending), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                idx;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              stall;
    logic              pend;
    logic              perr;
  } exp_t;

  typedef struct {
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              ll_valid;
    logic [ADDR_W-1:0] ll_waddr;
    logic [DATA_W-1:0] ll_wdata;
    exp_t              exp;
  } vec_t;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i,
                         input logic av, input int aa, input int ad,
                         input logic lv, input int la, input int ld,
                         input logic e_we, input int e_wa, input int e_wd,
                         input logic e_rdy, input logic e_stl, input logic e_pnd,
                         input logic e_perr);
    vecs[i].alu_valid = av;
    vecs[i].alu_waddr = ADDR_W'(aa);
    vecs[i].alu_wdata = DATA_W'(ad);
    vecs[i].ll_valid  = lv;
    vecs[i].ll_waddr  = ADDR_W'(la);
    vecs[i].ll_wdata  = DATA_W'(ld);
    vecs[i].exp.idx   = i;
    vecs[i].exp.we    = e_we;
    vecs[i].exp.waddr = ADDR_W'(e_wa);
    vecs[i].exp.wdata = DATA_W'(e_wd);
    vecs[i].exp.ready = e_rdy;
    vecs[i].exp.stall = e_stl;
    vecs[i].exp.pend  = e_pnd;
    vecs[i].exp.perr  = e_perr;
  endtask

  task automatic drive(input logic av, input int aa, input int ad,
                       input logic lv, input int la, input int ld);
    alu_valid = av;
    alu_waddr = ADDR_W'(aa);
    alu_wdata = DATA_W'(ad);
    ll_valid  = lv;
    ll_waddr  = ADDR_W'(la);
    ll_wdata  = DATA_W'(ld);
  endtask

  task automatic compare_next();
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: queue empty, expected an entry");
      return;
    end
    n_cmp--;
    e = exp_q.pop_front();
    check($sformatf("v%0d.we", e.idx), 32'(we), 32'(e.we));
    if (e.we) begin
      check($sformatf("v%0d.waddr", e.idx), 32'(waddr), 32'(e.waddr));
      check($sformatf("v%0d.wdata", e.idx), wdata, e.wdata);
    end
    check($sformatf("v%0d.ll_ready", e.idx), 32'(ll_ready), 32'(e.ready));
    check($sformatf("v%0d.stall_req", e.idx), 32'(stall_req), 32'(e.stall));
    check($sformatf("v%0d.ll_pending", e.idx), 32'(ll_pending), 32'(e.pend));
    check($sformatf("v%0d.proto_err", e.idx), 32'(proto_err), 32'(e.perr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //        idx alu:v addr data    ll:v addr data   exp:we waddr wdata  rdy stl pnd perr
    set_vec( 0, 1,  5, 'h1234,  0,  0, 0,       1,  5, 'h1234, 1, 0, 0, 0); // basic ALU write
    set_vec( 1, 1,  0, 'h5555,  0,  0, 0,       0,  0, 0,      1, 0, 0, 0); // ALU to r0 dropped
    set_vec( 2, 0,  0, 0,       1,  7, 'hAA,    0,  0, 0,      1, 0, 1, 0); // LL push
    set_vec( 3, 0,  0, 0,       0,  0, 0,       1,  7, 'hAA,   1, 0, 0, 0); // pop, pending falls
    set_vec( 4, 0,  0, 0,       0,  0, 0,       0,  0, 0,      1, 0, 0, 0);
    set_vec( 5, 0,  0, 0,       1,  9, 'h1,     0,  0, 0,      1, 0, 1, 0); // queue r9=1
    set_vec( 6, 1,  9, 'h2,     0,  0, 0,       1,  9, 'h2,    1, 0, 0, 0); // ALU r9=2 squashes
    set_vec( 7, 0,  0, 0,       0,  0, 0,       0,  0, 0,      1, 0, 0, 0); // dead pop, no write
    set_vec( 8, 1,  3, 'h33,    1,  3, 'h44,    1,  3, 'h33,   1, 0, 0, 0); // same-cycle squash
    set_vec( 9, 0,  0, 0,       0,  0, 0,       0,  0, 0,      1, 0, 0, 0);
    set_vec(10, 1,  1, 'h10,    1, 12, 'hC0,    1,  1, 'h10,   1, 0, 1, 0); // fill while ALU busy
    set_vec(11, 1,  2, 'h20,    1, 13, 'hD0,    1,  2, 'h20,   0, 0, 1, 0); // full
    set_vec(12, 1,  4, 'h40,    1, 14, 'hE0,    1,  4, 'h40,   0, 0, 1, 0); // push refused
    set_vec(13, 1,  6, 'h60,    0,  0, 0,       1,  6, 'h60,   0, 1, 1, 0); // 3rd unserved: stall
    set_vec(14, 0,  0, 0,       1, 15, 'hF0,    1, 12, 'hC0,   1, 0, 1, 0); // forced pop, push refused
    set_vec(15, 0,  0, 0,       1, 16, 'hF1,    1, 13, 'hD0,   1, 0, 1, 0); // push+pop, count same
    set_vec(16, 0,  0, 0,       0,  0, 0,       1, 16, 'hF1,   1, 0, 0, 0);
    set_vec(17, 0,  0, 0,       0,  0, 0,       0,  0, 0,      1, 0, 0, 0);
    set_vec(18, 1,  1, 'h1,     1, 20, 'h200,   1,  1, 'h1,    1, 0, 1, 0); // second episode
    set_vec(19, 1,  2, 'h2,     1, 21, 'h210,   1,  2, 'h2,    0, 0, 1, 0);
    set_vec(20, 1,  3, 'h3,     0,  0, 0,       1,  3, 'h3,    0, 0, 1, 0);
    set_vec(21, 1,  4, 'h4,     0,  0, 0,       1,  4, 'h4,    0, 1, 1, 0);
    set_vec(22, 1,  5, 'h5,     0,  0, 0,       1,  5, 'h5,    0, 0, 1, 1); // ALU during stall
    set_vec(23, 0,  0, 0,       0,  0, 0,       1, 20, 'h200,  1, 0, 1, 1);
    set_vec(24, 0,  0, 0,       0,  0, 0,       1, 21, 'h210,  1, 0, 0, 1);
    set_vec(25, 0,  0, 0,       0,  0, 0,       0,  0, 0,      1, 0, 0, 1); // proto_err sticky

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.we", 32'(we), 32'd0);
    check("rst.waddr", 32'(waddr), 32'd0);
    check("rst.wdata", wdata, 32'd0);
    check("rst.stall_req", 32'(stall_req), 32'd0);
    check("rst.proto_err", 32'(proto_err), 32'd0);
    check("rst.ll_ready", 32'(ll_ready), 32'd1);
    check("rst.ll_pending", 32'(ll_pending), 32'd0);
    rst = 1'b0;

    // Vector table through the scoreboard
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      if (i > 0) compare_next();
      drive(vecs[i].alu_valid, int'(vecs[i].alu_waddr), int'(vecs[i].alu_wdata),
            vecs[i].ll_valid, int'(vecs[i].ll_waddr), int'(vecs[i].ll_wdata));
      exp_q.push_back(vecs[i].exp);
    end
    @(negedge clk);
    compare_next();

    // Reset with two queued entries
    drive(1, 7, 'h7, 1, 22, 'h220);
    @(negedge clk);
    drive(1, 8, 'h8, 1, 23, 'h230);
    @(negedge clk);
    check("prerst.ll_ready", 32'(ll_ready), 32'd0);
    check("prerst.ll_pending", 32'(ll_pending), 32'd1);
    check("prerst.proto_err", 32'(proto_err), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.we", 32'(we), 32'd0);
    check("midrst.ll_ready", 32'(ll_ready), 32'd1);
    check("midrst.ll_pending", 32'(ll_pending), 32'd0);
    check("midrst.stall_req", 32'(stall_req), 32'd0);
    check("midrst.proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("postrst%0d.we", k), 32'(we), 32'd0);
      check($sformatf("postrst%0d.ll_pending", k), 32'(ll_pending), 32'd0);
      check($sformatf("postrst%0d.ll_ready", k), 32'(ll_ready), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that drives the single write port (we/waddr/wdata) of the general-purpose register file. It merges the single-cycle ALU result stream with results from long-latency units (multiply/divide/load) through a small in-order queue. It suppresses writes to register 0 and squashes stale queued results overwritten by younger ALU writes. It raises a stall request to the pipeline when queued results starve.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- DEPTH, 2, long-latency queue entries (power of two, ≥2)
- STARVE_LIMIT, 3, consecutive unserved cycles before stall_req

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_waddr  in  ADDR_W  ALU destination register
- alu_wdata  in  DATA_W  ALU result
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  queue accepts; transfer when ll_valid && ll_ready
- ll_waddr  in  ADDR_W  long-latency destination
- ll_wdata  in  DATA_W  long-latency result
- we  out  1  register file write enable (registered)
- waddr  out  ADDR_W  register file write address (registered)
- wdata  out  DATA_W  register file write data (registered)
- stall_req  out  1  pipeline must present alu_valid=0 next cycle
- ll_pending  out  1  queue holds ≥1 live entry
- proto_err  out  1  sticky: alu_valid seen while stall_req high

## Operation
- Queue: DEPTH-entry FIFO, each entry {live, addr, data}; count, rd/wr pointers wrap modulo DEPTH.
- ll_ready = (count < DEPTH), from registered count only; no same-cycle pop-through when full.
- Push on ll_valid && ll_ready; entry live=1 unless ll_waddr==0 (pushed dead).
- Per-cycle grant, evaluated in order:
  - ALU write if alu_valid && alu_waddr!=0.
  - Else pop head if count>0: write only if head live; dead head popped with we=0.
  - Else idle, we=0.
- ALU with alu_waddr==0: no write; cycle is free for the queue.
- Squash: accepted ALU write clears live on every queued entry with equal addr. The same-cycle push is also squashed if its address matches. ALU results are always younger than queued results.
- Starve counter: increments each cycle count>0 and no pop occurs; clears on pop or when empty; saturates at STARVE_LIMIT.
- stall_req = registered (counter == STARVE_LIMIT−1 and this cycle is unserved); the next cycle is guaranteed to pop.
- If alu_valid arrives while stall_req=1: ALU still wins, proto_err sets (cleared only by rst).
- ll_pending = OR of live bits of valid entries.

## Timing
- Reset values: we=0, waddr=0, wdata=0, stall_req=0, proto_err=0, count=0, pointers=0, starve counter=0, ll_ready=1 on first post-reset cycle.
- Latency: ALU input at edge N → we/waddr/wdata valid after edge N+1 (one cycle).
- Queue: push at edge N; earliest pop grant cycle N+1; write visible after edge N+2.
- Simultaneous push+pop when count==DEPTH: pop only (ll_ready=0); push+pop at count<DEPTH: count unchanged.
- Reset mid-operation: all queued entries discarded, no write issued in the reset cycle or the cycle after.
- stall_req is a one-cycle pulse per starvation episode; counter clears on the forced pop.

## Test plan
- Reset then alu_valid=1, addr=5, data=0x1234 → next cycle we=1, waddr=5, wdata=0x1234; addr=0 → we=0.
- LL push addr=7 data=0xAA with no ALU traffic → we=1, waddr=7 two cycles after push; ll_pending falls with the pop.
- Fill queue (2 pushes) while ALU writes every cycle → ll_ready=0, stall_req pulses after 3 unserved cycles; with alu_valid=0 next cycle, addr of the head is written; ll_ready returns 1.
- Queue addr=9 data=0x1; ALU writes addr=9 data=0x2 → later pop gives we=0; register 9 holds 0x2 only.
- alu_valid=1 during stall_req=1 → ALU write issued, proto_err=1 and stays high until rst.
- Assert rst with 2 queued entries → no further we; ll_ready=1, ll_pending=0 afterward.
